// File: rtl/alu_lane_splitter_if.sv
// alu_lane_splitter_if
//   Bundles the instruction-side and packet-side handshakes of the ALU lane
//   splitter. The splitter connects through the slave modport; the feeder and
//   consumer environment drive through the master modport.
//
//   Instruction side (master -> slave): valid_in, hdr_in, tmask_in, data_in;
//                                       ready_in flows back.
//   Packet side (slave -> master):      valid_out, hdr_out, tmask_out, data_out,
//                                       pid_out, sop_out, eop_out;
//                                       ready_out flows back.
interface alu_lane_splitter_if #(
    parameter int THREAD_CNT = 4,
    parameter int NUM_LANES  = 2,
    parameter int HDR_DATAW  = 64,
    parameter int LANE_DATAW = 64
);
    localparam int NUM_PACKETS = THREAD_CNT / NUM_LANES;
    localparam int PID_BITS    = $clog2(NUM_PACKETS);
    localparam int PID_WIDTH   = (PID_BITS > 0) ? PID_BITS : 1;

    logic                             valid_in;
    logic                             ready_in;
    logic [HDR_DATAW-1:0]             hdr_in;
    logic [THREAD_CNT-1:0]            tmask_in;
    logic [THREAD_CNT*LANE_DATAW-1:0] data_in;

    logic                             valid_out;
    logic                             ready_out;
    logic [HDR_DATAW-1:0]             hdr_out;
    logic [NUM_LANES-1:0]             tmask_out;
    logic [NUM_LANES*LANE_DATAW-1:0]  data_out;
    logic [PID_WIDTH-1:0]             pid_out;
    logic                             sop_out;
    logic                             eop_out;

    modport master (
        output valid_in, hdr_in, tmask_in, data_in, ready_out,
        input  ready_in, valid_out, hdr_out, tmask_out, data_out,
               pid_out, sop_out, eop_out
    );

    modport slave (
        input  valid_in, hdr_in, tmask_in, data_in, ready_out,
        output ready_in, valid_out, hdr_out, tmask_out, data_out,
               pid_out, sop_out, eop_out
    );
endinterface

// File: rtl/alu_lane_splitter.sv
// alu_lane_splitter
//   Accepts one full-width warp instruction (THREAD_CNT lanes) per handshake
//   and replays it as THREAD_CNT/NUM_LANES narrow packets of NUM_LANES lanes.
//   Each packet carries the shared header plus pid/sop/eop so downstream units
//   can reassemble the warp result.
//
//   Ports:
//     clk    - clock
//     reset  - synchronous, active-high; drops any buffered instruction
//     bus    - alu_lane_splitter_if.slave (instruction in, packets out)
//
//   Optional build macro ALU_SPLIT_SKIP_EMPTY_EN:
//     defined   - batches with an all-zero thread mask are not emitted
//     undefined - every batch is emitted in order 0..NUM_PACKETS-1
//   In both builds an all-zero instruction mask yields exactly one packet
//   (pid 0, sop and eop set).
module alu_lane_splitter #(
    parameter int THREAD_CNT = 4,
    parameter int NUM_LANES  = 2,
    parameter int HDR_DATAW  = 64,
    parameter int LANE_DATAW = 64
) (
    input logic                clk,
    input logic                reset,
    alu_lane_splitter_if.slave bus
);
    localparam int NUM_PACKETS = THREAD_CNT / NUM_LANES;
    localparam int PID_BITS    = $clog2(NUM_PACKETS);
    localparam int PID_WIDTH   = (PID_BITS > 0) ? PID_BITS : 1;
    localparam int PKT_DATAW   = NUM_LANES * LANE_DATAW;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                           state_q, state_d;
    logic [PID_WIDTH-1:0]             pid_q, pid_d;
    logic                             sop_q, sop_d;
    logic                             load;

    logic [HDR_DATAW-1:0]             hdr_buf;
    logic [THREAD_CNT-1:0]            tmask_buf;
    logic [THREAD_CNT*LANE_DATAW-1:0] data_buf;

    logic [PID_WIDTH-1:0]             first_pid;
    logic [PID_WIDTH-1:0]             next_pid;
    logic                             eop_raw;
    logic [NUM_LANES-1:0]             tmask_sel;
    logic [PKT_DATAW-1:0]             data_sel;

`ifdef ALU_SPLIT_SKIP_EMPTY_EN
    // One flag per batch: does this batch have any active thread?
    logic [NUM_PACKETS-1:0] in_nz;
    logic [NUM_PACKETS-1:0] buf_nz;

    always_comb begin
        in_nz  = '0;
        buf_nz = '0;
        for (int b = 0; b < NUM_PACKETS; b++) begin
            in_nz[b]  = |bus.tmask_in[b*NUM_LANES +: NUM_LANES];
            buf_nz[b] = |tmask_buf[b*NUM_LANES +: NUM_LANES];
        end
    end

    // Lowest non-empty batch of the incoming instruction; an all-empty
    // instruction falls back to batch 0 so it still produces one packet.
    always_comb begin
        first_pid = '0;
        for (int b = NUM_PACKETS - 1; b >= 0; b--) begin
            if (in_nz[b]) begin
                first_pid = PID_WIDTH'(b);
            end
        end
    end

    // Nearest non-empty batch strictly above the current pid. If none exists
    // the current packet is the last one.
    always_comb begin
        next_pid = pid_q;
        eop_raw  = 1'b1;
        for (int b = NUM_PACKETS - 1; b >= 0; b--) begin
            if (buf_nz[b] && (b > int'(pid_q))) begin
                next_pid = PID_WIDTH'(b);
                eop_raw  = 1'b0;
            end
        end
    end
`else
    assign first_pid = '0;
    assign next_pid  = pid_q + PID_WIDTH'(1);
    // An empty instruction collapses to a single packet at pid 0.
    assign eop_raw   = (pid_q == PID_WIDTH'(NUM_PACKETS - 1)) || (tmask_buf == '0);
`endif

    // Select the batch addressed by pid from the held instruction.
    always_comb begin
        tmask_sel = '0;
        data_sel  = '0;
        for (int b = 0; b < NUM_PACKETS; b++) begin
            if (pid_q == PID_WIDTH'(b)) begin
                tmask_sel = tmask_buf[b*NUM_LANES +: NUM_LANES];
                data_sel  = data_buf[b*PKT_DATAW +: PKT_DATAW];
            end
        end
    end

    // A new instruction is taken when empty, or in the same cycle the last
    // packet of the current one leaves, so back-to-back warps see no bubble.
    assign bus.ready_in  = (state_q == IDLE) || (bus.ready_out && eop_raw);

    assign bus.valid_out = (state_q == BUSY);
    assign bus.hdr_out   = hdr_buf;
    assign bus.tmask_out = tmask_sel;
    assign bus.data_out  = data_sel;
    assign bus.pid_out   = pid_q;
    assign bus.sop_out   = sop_q;
    assign bus.eop_out   = (state_q == BUSY) && eop_raw;

    // Next-state logic: load, advance through batches, or return to idle.
    always_comb begin
        state_d = state_q;
        pid_d   = pid_q;
        sop_d   = sop_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    load    = 1'b1;
                    state_d = BUSY;
                    pid_d   = first_pid;
                    sop_d   = 1'b1;
                end
            end
            BUSY: begin
                if (bus.ready_out) begin
                    if (!eop_raw) begin
                        pid_d = next_pid;
                        sop_d = 1'b0;
                    end else if (bus.valid_in) begin
                        load  = 1'b1;
                        pid_d = first_pid;
                        sop_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        pid_d   = '0;
                        sop_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pid_q   <= '0;
            sop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            sop_q   <= sop_d;
        end
    end

    // Payload buffers need no reset; they are only observed while BUSY.
    always_ff @(posedge clk) begin
        if (load) begin
            hdr_buf   <= bus.hdr_in;
            tmask_buf <= bus.tmask_in;
            data_buf  <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_alu_lane_splitter.sv
// tb_alu_lane_splitter
//   Self-checking bench for alu_lane_splitter. A queue of expected packets is
//   built from each accepted instruction and compared against the DUT every
//   cycle; directed scenarios pin literal values, then random traffic runs.
module tb_alu_lane_splitter;
    localparam int THREAD_CNT  = 4;
    localparam int NUM_LANES   = 2;
    localparam int HDR_DATAW   = 64;
    localparam int LANE_DATAW  = 64;
    localparam int NUM_PACKETS = THREAD_CNT / NUM_LANES;
    localparam int PID_WIDTH   = ($clog2(NUM_PACKETS) > 0) ? $clog2(NUM_PACKETS) : 1;
    localparam int PKT_DATAW   = NUM_LANES * LANE_DATAW;
    localparam int IN_DATAW    = THREAD_CNT * LANE_DATAW;

    typedef struct {
        logic [HDR_DATAW-1:0] hdr;
        logic [NUM_LANES-1:0] tmask;
        logic [PKT_DATAW-1:0] data;
        logic [PID_WIDTH-1:0] pid;
        logic                 sop;
        logic                 eop;
    } pkt_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;
    pkt_t exp_q[$];

    alu_lane_splitter_if #(
        .THREAD_CNT(THREAD_CNT), .NUM_LANES(NUM_LANES),
        .HDR_DATAW(HDR_DATAW), .LANE_DATAW(LANE_DATAW)
    ) bus ();

    alu_lane_splitter #(
        .THREAD_CNT(THREAD_CNT), .NUM_LANES(NUM_LANES),
        .HDR_DATAW(HDR_DATAW), .LANE_DATAW(LANE_DATAW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [PKT_DATAW-1:0] act,
                               input logic [PKT_DATAW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected packet list for one instruction, straight from the batching rules.
    task automatic pushInstr(input logic [HDR_DATAW-1:0] hdr, input logic [THREAD_CNT-1:0] tmask,
                             input logic [IN_DATAW-1:0] data);
        pkt_t p;
        int   emit_list[$];
        logic [NUM_LANES-1:0] m;
        if (tmask == '0) begin
            emit_list.push_back(0);
        end else begin
            for (int b = 0; b < NUM_PACKETS; b++) begin
                m = tmask[b*NUM_LANES +: NUM_LANES];
`ifdef ALU_SPLIT_SKIP_EMPTY_EN
                if (m != '0) emit_list.push_back(b);
`else
                emit_list.push_back(b);
`endif
            end
        end
        for (int k = 0; k < emit_list.size(); k++) begin
            p.hdr   = hdr;
            p.tmask = tmask[emit_list[k]*NUM_LANES +: NUM_LANES];
            p.data  = data[emit_list[k]*PKT_DATAW +: PKT_DATAW];
            p.pid   = PID_WIDTH'(emit_list[k]);
            p.sop   = (k == 0);
            p.eop   = (k == emit_list.size() - 1);
            exp_q.push_back(p);
        end
    endtask

    // Per-cycle comparison against the expected packet queue.
    always @(negedge clk) begin
        bit exp_valid;
        bit exp_ready;
        if (check_en) begin
            exp_valid = (exp_q.size() > 0);
            exp_ready = !exp_valid || (bus.ready_out && exp_q[0].eop);
            checkOutput("valid_out", PKT_DATAW'(bus.valid_out), PKT_DATAW'(exp_valid));
            checkOutput("ready_in", PKT_DATAW'(bus.ready_in), PKT_DATAW'(exp_ready));
            if (exp_valid && bus.valid_out) begin
                checkOutput("hdr_out", PKT_DATAW'(bus.hdr_out), PKT_DATAW'(exp_q[0].hdr));
                checkOutput("pid_out", PKT_DATAW'(bus.pid_out), PKT_DATAW'(exp_q[0].pid));
                checkOutput("tmask_out", PKT_DATAW'(bus.tmask_out), PKT_DATAW'(exp_q[0].tmask));
                checkOutput("data_out", bus.data_out, exp_q[0].data);
                checkOutput("sop_out", PKT_DATAW'(bus.sop_out), PKT_DATAW'(exp_q[0].sop));
                checkOutput("eop_out", PKT_DATAW'(bus.eop_out), PKT_DATAW'(exp_q[0].eop));
            end
            if (reset) begin
                exp_q.delete();
            end else begin
                if (exp_valid && bus.ready_out) void'(exp_q.pop_front());
                if (bus.valid_in && exp_ready) pushInstr(bus.hdr_in, bus.tmask_in, bus.data_in);
            end
        end
    end

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic applyStimulus(input logic [HDR_DATAW-1:0] hdr, input logic [THREAD_CNT-1:0] tmask,
                                 input logic [IN_DATAW-1:0] data);
        bit got = 1'b0;
        bus.valid_in = 1'b1;
        bus.hdr_in   = hdr;
        bus.tmask_in = tmask;
        bus.data_in  = data;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.ready_in) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got ready_in 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    // Literal check of the packet visible at the next sampling point.
    task automatic expectPacket(input string name, input logic [HDR_DATAW-1:0] hdr, input int pid,
                                input logic [NUM_LANES-1:0] tmask, input logic [PKT_DATAW-1:0] data,
                                input bit sop, input bit eop);
        @(negedge clk);
        checkOutput({name, "_valid"}, PKT_DATAW'(bus.valid_out), PKT_DATAW'(1));
        checkOutput({name, "_hdr"}, PKT_DATAW'(bus.hdr_out), PKT_DATAW'(hdr));
        checkOutput({name, "_pid"}, PKT_DATAW'(bus.pid_out), PKT_DATAW'(pid));
        checkOutput({name, "_tmask"}, PKT_DATAW'(bus.tmask_out), PKT_DATAW'(tmask));
        checkOutput({name, "_data"}, bus.data_out, data);
        checkOutput({name, "_sop"}, PKT_DATAW'(bus.sop_out), PKT_DATAW'(sop));
        checkOutput({name, "_eop"}, PKT_DATAW'(bus.eop_out), PKT_DATAW'(eop));
    endtask

    task automatic randomPayload();
        bus.hdr_in = {$urandom, $urandom};
        bus.tmask_in = THREAD_CNT'($urandom_range(0, (1 << THREAD_CNT) - 1));
        if ($urandom_range(0, 3) == 0) bus.tmask_in = '0;
        for (int t = 0; t < THREAD_CNT; t++) begin
            bus.data_in[t*LANE_DATAW +: LANE_DATAW] = {$urandom, $urandom};
        end
    endtask

    initial begin
        bit accepted;
        reset         = 1'b1;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        bus.hdr_in    = '0;
        bus.tmask_in  = '0;
        bus.data_in   = '0;

        syncDrive();
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("rst_valid_out", PKT_DATAW'(bus.valid_out), PKT_DATAW'(0));
        checkOutput("rst_pid_out", PKT_DATAW'(bus.pid_out), PKT_DATAW'(0));
        checkOutput("rst_sop_out", PKT_DATAW'(bus.sop_out), PKT_DATAW'(0));
        checkOutput("rst_eop_out", PKT_DATAW'(bus.eop_out), PKT_DATAW'(0));
        checkOutput("rst_ready_in", PKT_DATAW'(bus.ready_in), PKT_DATAW'(1));
        syncDrive();
        reset         = 1'b0;
        bus.ready_out = 1'b1;

        // Full mask, two packets with 1-cycle latency.
        applyStimulus(64'h1111, 4'b1111, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        expectPacket("full_p0", 64'h1111, 0, 2'b11, {64'hA1, 64'hA0}, 1'b1, 1'b0);
        expectPacket("full_p1", 64'h1111, 1, 2'b11, {64'hA3, 64'hA2}, 1'b0, 1'b1);
        checkOutput("full_ready_in_eop", PKT_DATAW'(bus.ready_in), PKT_DATAW'(1));

        // Lower batch empty.
        syncDrive();
        applyStimulus(64'h2222, 4'b1100, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
`ifdef ALU_SPLIT_SKIP_EMPTY_EN
        expectPacket("skip_p1", 64'h2222, 1, 2'b11, {64'hB3, 64'hB2}, 1'b1, 1'b1);
`else
        expectPacket("hole_p0", 64'h2222, 0, 2'b00, {64'hB1, 64'hB0}, 1'b1, 1'b0);
        expectPacket("hole_p1", 64'h2222, 1, 2'b11, {64'hB3, 64'hB2}, 1'b0, 1'b1);
`endif

        // All-zero mask: exactly one packet.
        syncDrive();
        applyStimulus(64'h3333, 4'b0000, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
        expectPacket("zero_p0", 64'h3333, 0, 2'b00, {64'hC1, 64'hC0}, 1'b1, 1'b1);
        checkOutput("zero_ready_in", PKT_DATAW'(bus.ready_in), PKT_DATAW'(1));

        // Backpressure on pid 0 for three cycles.
        syncDrive();
        bus.ready_out = 1'b0;
        applyStimulus(64'h4444, 4'b1111, {64'hD3, 64'hD2, 64'hD1, 64'hD0});
        for (int i = 0; i < 3; i++) begin
            expectPacket("hold_p0", 64'h4444, 0, 2'b11, {64'hD1, 64'hD0}, 1'b1, 1'b0);
            checkOutput("hold_ready_in", PKT_DATAW'(bus.ready_in), PKT_DATAW'(0));
        end
        syncDrive();
        bus.ready_out = 1'b1;
        expectPacket("rel_p0", 64'h4444, 0, 2'b11, {64'hD1, 64'hD0}, 1'b1, 1'b0);
        expectPacket("rel_p1", 64'h4444, 1, 2'b11, {64'hD3, 64'hD2}, 1'b0, 1'b1);

        // Back-to-back instructions: four consecutive packets, no bubble.
        syncDrive();
        applyStimulus(64'h5555, 4'b1111, {64'hE3, 64'hE2, 64'hE1, 64'hE0});
        fork
            applyStimulus(64'h6666, 4'b1111, {64'hF3, 64'hF2, 64'hF1, 64'hF0});
            begin
                expectPacket("b2b_a0", 64'h5555, 0, 2'b11, {64'hE1, 64'hE0}, 1'b1, 1'b0);
                expectPacket("b2b_a1", 64'h5555, 1, 2'b11, {64'hE3, 64'hE2}, 1'b0, 1'b1);
                expectPacket("b2b_b0", 64'h6666, 0, 2'b11, {64'hF1, 64'hF0}, 1'b1, 1'b0);
                expectPacket("b2b_b1", 64'h6666, 1, 2'b11, {64'hF3, 64'hF2}, 1'b0, 1'b1);
            end
        join

        // Reset while pid 1 waits under backpressure.
        syncDrive();
        applyStimulus(64'h7777, 4'b1111, {64'h73, 64'h72, 64'h71, 64'h70});
        expectPacket("rst_p0", 64'h7777, 0, 2'b11, {64'h71, 64'h70}, 1'b1, 1'b0);
        syncDrive();
        bus.ready_out = 1'b0;
        reset         = 1'b1;
        expectPacket("rst_p1", 64'h7777, 1, 2'b11, {64'h73, 64'h72}, 1'b0, 1'b1);
        syncDrive();
        reset         = 1'b0;
        bus.ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rst_drop_valid", PKT_DATAW'(bus.valid_out), PKT_DATAW'(0));
            checkOutput("rst_drop_ready_in", PKT_DATAW'(bus.ready_in), PKT_DATAW'(1));
        end

        // Random traffic with random backpressure and occasional reset.
        syncDrive();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.ready_out = ($urandom_range(0, 3) != 0);
            reset         = ($urandom_range(0, 99) == 0);
            if (!bus.valid_in && ($urandom_range(0, 1) == 1)) begin
                bus.valid_in = 1'b1;
                randomPayload();
            end
            @(negedge clk);
            accepted = bus.valid_in && bus.ready_in && !reset;
            syncDrive();
            if (accepted) bus.valid_in = 1'b0;
        end

        // Drain.
        reset         = 1'b0;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        repeat (10) syncDrive();
        checkOutput("drain_empty", PKT_DATAW'(exp_q.size()), PKT_DATAW'(0));
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_lane_splitter.md
Name: alu_lane_splitter

Overview:
Upstream feeder for the ALU block's per-block execute path. Accepts one full-width warp instruction (THREAD_CNT lanes) per handshake and serializes it into THREAD_CNT/NUM_LANES narrow packets of NUM_LANES lanes each. Each packet carries pid/sop/eop so the downstream int/muldiv units and the gather stage can reassemble the result. Output is fully registered with valid/ready handshakes on both sides.

Parameters:
THREAD_CNT, 4, threads per warp; power of two
NUM_LANES, 2, lanes per output packet; power of two, divides THREAD_CNT
HDR_DATAW, 64, width of shared header (uuid, wid, op, op_mod, rd, wb, PC...), copied unchanged to every packet
LANE_DATAW, 64, per-lane payload width (rs1/rs2/rs3 data)
Derived: NUM_PACKETS = THREAD_CNT/NUM_LANES; PID_BITS = CLOG2(NUM_PACKETS); PID_WIDTH = UP(PID_BITS)

Ports:
clk  input  1  clock
reset  input  1  reset
valid_in  input  1  input instruction valid
ready_in  output  1  splitter can accept input
hdr_in  input  HDR_DATAW  shared header
tmask_in  input  THREAD_CNT  thread mask
data_in  input  THREAD_CNT*LANE_DATAW  per-thread payload, thread 0 in LSBs
valid_out  output  1  packet valid
ready_out  input  1  downstream accepts packet
hdr_out  output  HDR_DATAW  registered copy of hdr_in
tmask_out  output  NUM_LANES  tmask_in slice for current pid
data_out  output  NUM_LANES*LANE_DATAW  data_in slice for current pid
pid_out  output  PID_WIDTH  packet index (thread base = pid*NUM_LANES)
sop_out  output  1  first packet of instruction
eop_out  output  1  last packet of instruction

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- Reset values: valid_out=0, pid_out=0, sop_out=0, eop_out=0, state=IDLE; hdr/data/tmask buffers don't-care.
- States: IDLE (buffer empty), BUSY (buffer holds instruction, valid_out=1).
- ready_in = (state==IDLE) || (valid_out && ready_out && eop_out). Allows back-to-back instructions with no bubble.
- Input fire (valid_in && ready_in): latch hdr/tmask/data; pid = first emitted batch; state=BUSY; valid_out=1 next cycle. Latency input fire -> first valid_out = 1 cycle.
- Slicing: tmask_out = tmask_buf[pid*NUM_LANES +: NUM_LANES]; data_out likewise at LANE_DATAW granularity. Combinational from buffer + pid register.
- sop_out = 1 on the first emitted packet of an instruction, 0 afterwards.
- eop_out = 1 when no further batch will be emitted (pid==NUM_PACKETS-1, or per optional feature).
- Output fire without eop: pid advances to next emitted batch, sop cleared, state stays BUSY.
- Output fire with eop: if valid_in same cycle, load new instruction (state BUSY, valid_out stays 1); else state=IDLE, valid_out=0.
- valid_out && !ready_out: all outputs held stable until fire.
- NUM_PACKETS==1: single packet pid=0, sop=eop=1; block reduces to one register stage.
- tmask_in all zero: exactly one packet, pid=0, tmask_out=0, sop=eop=1 (both modes).
- Reset mid-operation: buffered instruction dropped, valid_out=0 from next cycle, no partial packet later.

Optional Feature:
Macro ALU_SPLIT_SKIP_EMPTY_EN.
- Defined: batches whose tmask slice is zero are skipped; first pid = lowest non-empty batch; advance = next non-empty batch (priority search above current pid); eop = no non-empty batch above current pid. Non-empty instruction emits only non-empty packets, so pid values may be non-contiguous.
- Undefined: all NUM_PACKETS batches emitted in order 0..NUM_PACKETS-1, including zero-mask ones; eop at pid==NUM_PACKETS-1 (except all-zero mask rule above).

Test Plan:
- THREAD_CNT=4, NUM_LANES=2, tmask_in=4'b1111, data_in threads 0..3 = 0xA0..0xA3, ready_out=1 -> cycle+1: pid0 tmask 2'b11 data {A1,A0} sop1 eop0; cycle+2: pid1 tmask 2'b11 data {A3,A2} sop0 eop1; ready_in high in cycle+2.
- tmask_in=4'b1100 with ALU_SPLIT_SKIP_EMPTY_EN -> one packet pid1 tmask 2'b11 sop=eop=1; without macro -> pid0 tmask 2'b00 sop1 eop0, then pid1 tmask 2'b11 sop0 eop1.
- tmask_in=4'b0000 -> exactly one packet pid0 tmask 2'b00 sop=eop=1 in both modes.
- Hold ready_out=0 for 3 cycles on pid0 -> valid_out, pid, data, sop, eop unchanged; ready_in=0; release -> pid1 next cycle.
- Two instructions back-to-back with valid_in held high -> second accepted in same cycle as first's eop fire; 4 consecutive valid_out cycles, no bubble, hdr_out switches with sop.
- Assert reset while pid1 pending under backpressure -> valid_out=0 next cycle, ready_in=1, no further packet for dropped instruction.
